// File: rtl/instr_fetch_unit.sv
// Fetch stage of the single-cycle MIPS datapath: owns the PC, fetches one word per instruction
// over a req/ready handshake, holds it for the datapath and commits the next PC on retire.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic             instr_valid,
    output logic [31:0]      instr,
    output logic [5:0]       opcode,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    input  logic             retire,
    input  logic             branch,
    input  logic             jump,
    input  logic             alu_zero,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned OPW = 6;

    // Alignment bits are forced to zero so a misconfigured RESET_PC cannot leak onto the bus.
    localparam logic [AW-1:0] RESET_PC_A = {RESET_PC[AW-1:2], 2'b00};

    typedef enum logic {
        S_REQ  = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             req_q, req_d;
    logic             valid_q, valid_d;
    logic [AW-1:0]    pc_q, pc_d;
    logic [AW-1:0]    pc_plus4_q, pc_plus4_d;
    logic [DW-1:0]    instr_q, instr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             xfer;
    logic             retire_fire;
    logic [AW-1:0]    br_off;
    logic [AW-1:0]    jmp_tgt;
    logic [AW-1:0]    next_pc;

    // req_q is low for the first cycle out of reset, so a response seen then is ignored.
    assign xfer        = req_q & imem_ready & (state_q == S_REQ);
    assign retire_fire = retire & (state_q == S_EXEC);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ:   if (xfer)        state_d = S_EXEC;
            S_EXEC:  if (retire_fire) state_d = S_REQ;
            default: state_d = S_REQ;
        endcase
    end

    // Next values of the registered outputs, including the jump > branch > sequential PC mux
    always_comb begin
        br_off     = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        jmp_tgt    = {pc_plus4_q[31:28], instr_q[25:0], 2'b00};
        next_pc    = pc_plus4_q;
        req_d      = (state_d == S_REQ);
        valid_d    = (state_d == S_EXEC);
        pc_d       = pc_q;
        instr_d    = instr_q;
        cnt_d      = cnt_q;

        if (jump) begin
            next_pc = jmp_tgt;
        end else if (branch && alu_zero) begin
            next_pc = pc_plus4_q + br_off;
        end

        if (xfer) begin
            instr_d = imem_rdata;
        end
        if (retire_fire) begin
            pc_d  = next_pc;
            cnt_d = cnt_q + CNT_W'(1);
        end
        pc_plus4_d = pc_d + AW'(4);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            pc_q       <= RESET_PC_A;
            pc_plus4_q <= RESET_PC_A + AW'(4);
            instr_q    <= '0;
            cnt_q      <= '0;
        end else begin
            req_q      <= req_d;
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            instr_q    <= instr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[DW-1:DW-OPW];
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_q;
    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, sequential fetch, wait states, beq, j, wrap.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        retire;
    logic        branch;
    logic        jump;
    logic        alu_zero;
    logic [31:0] retired_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .opcode(opcode), .pc(pc), .pc_plus4(pc_plus4),
        .retire(retire), .branch(branch), .jump(jump), .alu_zero(alu_zero), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, release, and advance one edge so imem_req is up.
    task automatic do_reset();
        tick();
        rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
        retire = 1'b0; branch = 1'b0; jump = 1'b0; alu_zero = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Zero-wait fetch of one word, then retire it with the given control signals.
    task automatic fetch_exec(input logic [31:0] data, input logic br, input logic jp, input logic z);
        imem_ready = 1'b1; imem_rdata = data;
        tick();
        imem_ready = 1'b0;
        branch = br; jump = jp; alu_zero = z; retire = 1'b1;
        tick();
        retire = 1'b0; branch = 1'b0; jump = 1'b0; alu_zero = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        fetch_exec(32'h2000_0001, 1'b0, 1'b0, 1'b0);
        imem_ready = 1'b1; imem_rdata = 32'h8C00_0004;
        tick();
        imem_ready = 1'b0;
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %b expected 1", instr_valid); end
        // asynchronous reset while a response is being offered
        rst_n = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h expected 00000000", pc); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", instr_valid); end
        n_checks++; if (retired_cnt !== 32'h0) begin n_fail++; $display("FAIL rst_cnt: got %0d expected 0", retired_cnt); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req_low: got %b expected 0", imem_req); end
        tick();
        tick();
        n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h expected 00000000", instr); end
        n_checks++; if (opcode !== 6'h0) begin n_fail++; $display("FAIL rst_opcode: got %h expected 00", opcode); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_req_high: got %b expected 1", imem_req); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_first_edge_valid: got %b expected 0", instr_valid); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h expected 00000000", imem_addr); end
        imem_ready = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            exp_addr = 32'(i * 4);
            n_checks++; if (imem_addr !== exp_addr) begin n_fail++; $display("FAIL seq_addr%0d: got %h expected %h", i, imem_addr, exp_addr); end
            n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL seq_req%0d: got %b expected 1", i, imem_req); end
            fetch_exec(32'h2000_0000 | 32'(i), 1'b0, 1'b0, 1'b0);
        end
        n_checks++; if (imem_addr !== 32'hC) begin n_fail++; $display("FAIL seq_addr3: got %h expected 0000000c", imem_addr); end
        n_checks++; if (pc_plus4 !== 32'h10) begin n_fail++; $display("FAIL seq_pc_plus4: got %h expected 00000010", pc_plus4); end
        n_checks++; if (retired_cnt !== 32'd3) begin n_fail++; $display("FAIL seq_cnt: got %0d expected 3", retired_cnt); end
    endtask

    task automatic test_wait_states();
        do_reset();
        fetch_exec(32'h2000_0000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL ws_addr%0d: got %h expected 00000004", i, imem_addr); end
            n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL ws_valid%0d: got %b expected 0", i, instr_valid); end
        end
        imem_ready = 1'b1; imem_rdata = 32'h8C22_0010;
        tick();
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL ws_valid_rise: got %b expected 1", instr_valid); end
        n_checks++; if (instr !== 32'h8C22_0010) begin n_fail++; $display("FAIL ws_instr: got %h expected 8c220010", instr); end
        n_checks++; if (opcode !== 6'h23) begin n_fail++; $display("FAIL ws_opcode: got %h expected 23", opcode); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL ws_req_drop: got %b expected 0", imem_req); end
        // memory traffic during execute must not disturb the held instruction
        imem_rdata = 32'hFFFF_FFFF;
        tick();
        n_checks++; if (instr !== 32'h8C22_0010) begin n_fail++; $display("FAIL ws_exec_hold: got %h expected 8c220010", instr); end
        imem_ready = 1'b0;
        retire = 1'b1;
        tick();
        retire = 1'b0;
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL ws_valid_drop: got %b expected 0", instr_valid); end
        n_checks++; if (pc !== 32'h8) begin n_fail++; $display("FAIL ws_pc: got %h expected 00000008", pc); end
    endtask

    task automatic test_beq();
        do_reset();
        for (int i = 0; i < 4; i++) fetch_exec(32'h0, 1'b0, 1'b0, 1'b0);
        fetch_exec(32'h1000_0003, 1'b1, 1'b0, 1'b1);
        n_checks++; if (pc !== 32'h20) begin n_fail++; $display("FAIL beq_taken: got %h expected 00000020", pc); end
        do_reset();
        for (int i = 0; i < 4; i++) fetch_exec(32'h0, 1'b0, 1'b0, 1'b0);
        fetch_exec(32'h1000_0003, 1'b1, 1'b0, 1'b0);
        n_checks++; if (pc !== 32'h14) begin n_fail++; $display("FAIL beq_not_taken: got %h expected 00000014", pc); end
        do_reset();
        for (int i = 0; i < 2; i++) fetch_exec(32'h0, 1'b0, 1'b0, 1'b0);
        fetch_exec(32'h1000_FFFF, 1'b1, 1'b0, 1'b1);
        n_checks++; if (pc !== 32'h8) begin n_fail++; $display("FAIL beq_self: got %h expected 00000008", pc); end
        n_checks++; if (retired_cnt !== 32'd3) begin n_fail++; $display("FAIL beq_cnt: got %0d expected 3", retired_cnt); end
    endtask

    task automatic test_jump();
        do_reset();
        fetch_exec(32'h0BFF_FFFF, 1'b0, 1'b1, 1'b0);
        n_checks++; if (pc !== 32'h0FFF_FFFC) begin n_fail++; $display("FAIL j_far: got %h expected 0ffffffc", pc); end
        fetch_exec(32'h0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (pc !== 32'h1000_0000) begin n_fail++; $display("FAIL j_region: got %h expected 10000000", pc); end
        imem_ready = 1'b1; imem_rdata = 32'h0800_0040;
        tick();
        imem_ready = 1'b0;
        n_checks++; if (opcode !== 6'h02) begin n_fail++; $display("FAIL j_opcode: got %h expected 02", opcode); end
        branch = 1'b1; jump = 1'b1; alu_zero = 1'b1; retire = 1'b1;
        tick();
        retire = 1'b0; branch = 1'b0; jump = 1'b0; alu_zero = 1'b0;
        n_checks++; if (pc !== 32'h1000_0100) begin n_fail++; $display("FAIL j_priority: got %h expected 10000100", pc); end
        n_checks++; if (pc_plus4 !== 32'h1000_0104) begin n_fail++; $display("FAIL j_pc_plus4: got %h expected 10000104", pc_plus4); end
    endtask

    task automatic test_wrap();
        do_reset();
        fetch_exec(32'h1000_FFFE, 1'b1, 1'b0, 1'b1);
        n_checks++; if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top: got %h expected fffffffc", pc); end
        n_checks++; if (pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc_plus4: got %h expected 00000000", pc_plus4); end
        fetch_exec(32'h0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h expected 00000000", pc); end
        n_checks++; if (retired_cnt !== 32'd2) begin n_fail++; $display("FAIL wrap_cnt: got %0d expected 2", retired_cnt); end
        // retire while still fetching has no effect
        retire = 1'b1; branch = 1'b1; alu_zero = 1'b1;
        tick();
        tick();
        retire = 1'b0; branch = 1'b0; alu_zero = 1'b0;
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL req_retire_pc: got %h expected 00000000", pc); end
        n_checks++; if (retired_cnt !== 32'd2) begin n_fail++; $display("FAIL req_retire_cnt: got %0d expected 2", retired_cnt); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL req_retire_valid: got %b expected 0", instr_valid); end
    endtask

    initial begin
        rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
        retire = 1'b0; branch = 1'b0; jump = 1'b0; alu_zero = 1'b0;
        test_reset();
        test_sequential();
        test_wait_states();
        test_beq();
        test_jump();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
